// File: rtl/adder_seq24_if.sv
// Operand/result bundle for adder_seq24. With ADDER_SEQ_SUB_EN defined the
// bundle also carries the sub_i mode select.
interface adder_seq24_if #(
    parameter int NSLICE = 4
);
    localparam int W = 6 * NSLICE;

    logic         start_i;
    logic [W-1:0] data0_i;
    logic [W-1:0] data1_i;
    logic         carry_i;
`ifdef ADDER_SEQ_SUB_EN
    logic         sub_i;
`endif
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         overflow_o;

`ifdef ADDER_SEQ_SUB_EN
    modport master (
        output start_i, data0_i, data1_i, carry_i, sub_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );
    modport slave (
        input  start_i, data0_i, data1_i, carry_i, sub_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
`else
    modport master (
        output start_i, data0_i, data1_i, carry_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );
    modport slave (
        input  start_i, data0_i, data1_i, carry_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
`endif
endinterface

// File: rtl/adder_seq24.sv
// Sequential NSLICE x 6-bit adder: one adder6 slice per clock, LSB slice first.
// Optional subtraction mode is compiled in with ADDER_SEQ_SUB_EN.
module adder6 (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       ci,
    output logic [5:0] s,
    output logic       co
);
    logic [6:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {6'b0, ci};
    assign s     = total[5:0];
    assign co    = total[6];
endmodule

module adder_seq24 #(
    parameter int NSLICE = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    adder_seq24_if.slave bus
);
    localparam int W  = 6 * NSLICE;
    localparam int IW = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic          carry_reg, carry_next;
    logic          cout_reg, cout_next;
    logic          ovf_reg, ovf_next;
    logic [5:0]    sum_reg  [NSLICE];
    logic [5:0]    sum_next [NSLICE];

    logic [5:0]    a_slc [NSLICE];
    logic [5:0]    b_slc [NSLICE];
    logic [W-1:0]  sum_flat;
    logic [5:0]    slice_sum;
    logic          slice_cout;
    logic          sub_sel;

`ifdef ADDER_SEQ_SUB_EN
    assign sub_sel = bus.sub_i;
`else
    assign sub_sel = 1'b0;
`endif

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign a_slc[gi]             = a_reg[6*gi +: 6];
        assign b_slc[gi]             = b_reg[6*gi +: 6];
        assign sum_flat[6*gi +: 6]   = sum_reg[gi];
    end

    adder6 u_adder6 (
        .a  (a_slc[idx_reg]),
        .b  (b_slc[idx_reg]),
        .ci (carry_reg),
        .s  (slice_sum),
        .co (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < NSLICE; i++) sum_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
            sum_reg   <= sum_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        sum_next   = sum_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    // Subtraction is A + ~B + 1; the stored operand is already B'.
                    a_next     = bus.data0_i;
                    b_next     = bus.data1_i ^ {W{sub_sel}};
                    carry_next = sub_sel | bus.carry_i;
                    idx_next   = '0;
                    cout_next  = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                sum_next[idx_reg] = slice_sum;
                carry_next        = slice_cout;
                idx_next          = idx_reg + 1'b1;
                if (idx_reg == LAST) begin
                    cout_next  = slice_cout;
                    ovf_next   = (a_reg[W-1] == b_reg[W-1]) && (slice_sum[5] != a_reg[W-1]);
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ready_o    = (state_reg == IDLE) || (state_reg == DONE);
    assign bus.valid_o    = (state_reg == DONE);
    assign bus.sum_o      = sum_flat;
    assign bus.carry_o    = cout_reg;
    assign bus.overflow_o = ovf_reg;
endmodule

// File: tb/tb_adder_seq24.sv
// Self-checking bench for adder_seq24: vector table plus corner sequences,
// with a scoreboard queue popped on every valid_o pulse.
module tb_adder_seq24;
    localparam int NSLICE = 4;
    localparam int W      = 6 * NSLICE;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
        int           acc;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_seq24_if #(.NSLICE(NSLICE)) bus_if();

    adder_seq24 #(.NSLICE(NSLICE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid = -1;
    int   prev_valid = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub,
                                logic [W-1:0] sum, logic c, logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.c = c; v.ovf = ovf;
        return v;
    endfunction

    // Reference: full-width add of A, B' and carry-in.
    function automatic vec_t model(vec_t v);
        vec_t         r;
        logic [W-1:0] bp;
        logic         ci;
        logic [W:0]   full;
        r    = v;
        bp   = v.sub ? ~v.b : v.b;
        ci   = v.sub ? 1'b1 : v.cin;
        full = {1'b0, v.a} + {1'b0, bp} + {{W{1'b0}}, ci};
        r.sum = full[W-1:0];
        r.c   = full[W];
        r.ovf = (v.a[W-1] == bp[W-1]) && (full[W-1] != v.a[W-1]);
        return r;
    endfunction

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus_if.ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    task automatic drive(vec_t v, string tag);
        exp_t e;
        bus_if.start_i = 1'b1;
        bus_if.data0_i = v.a;
        bus_if.data1_i = v.b;
        bus_if.carry_i = v.cin;
`ifdef ADDER_SEQ_SUB_EN
        bus_if.sub_i   = v.sub;
`endif
        e.sum = v.sum; e.c = v.c; e.ovf = v.ovf; e.acc = cyc + 1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(vec_t v, string tag);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            drive(v, tag);
            @(posedge clk);
            #1 bus_if.start_i = 1'b0;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.valid_o === 1'b1) begin
            prev_valid = last_valid;
            last_valid = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cycle=%0d actual=1 required=0", cyc);
            end else begin
                e = sb.pop_front();
                $display("op %s cycle=%0d sum=%h carry=%b ovf=%b (want %h %b %b)", e.tag, cyc,
                         bus_if.sum_o, bus_if.carry_o, bus_if.overflow_o, e.sum, e.c, e.ovf);
                check({e.tag, "_sum"}, bus_if.sum_o, e.sum);
                check({e.tag, "_carry"}, W'(bus_if.carry_o), W'(e.c));
                check({e.tag, "_ovf"}, W'(bus_if.overflow_o), W'(e.ovf));
                check({e.tag, "_latency"}, W'(cyc - e.acc), W'(NSLICE));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ok;
        vec_t v;
        int   n;

        bus_if.start_i = 1'b0;
        bus_if.data0_i = '0;
        bus_if.data1_i = '0;
        bus_if.carry_i = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
        bus_if.sub_i   = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", W'(bus_if.ready_o), W'(1));
        check("rst_valid", W'(bus_if.valid_o), W'(0));
        check("rst_sum", bus_if.sum_o, 24'h000000);
        check("rst_carry", W'(bus_if.carry_o), W'(0));
        check("rst_ovf", W'(bus_if.overflow_o), W'(0));

        vecs.push_back(mk(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0));
        vecs.push_back(mk(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1));
        vecs.push_back(mk(24'h000000, 24'h000000, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0));
        vecs.push_back(mk(24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1));
        vecs.push_back(mk(24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0));
        vecs.push_back(mk(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b0));
        vecs.push_back(mk(24'h03F03F, 24'h000FC1, 1'b0, 1'b0, 24'h040000, 1'b0, 1'b0));
        vecs.push_back(mk(24'h555555, 24'hAAAAAA, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0));
`ifdef ADDER_SEQ_SUB_EN
        vecs.push_back(mk(24'h000005, 24'h000007, 1'b1, 1'b1, 24'hFFFFFE, 1'b0, 1'b0));
        vecs.push_back(mk(24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0));
        vecs.push_back(mk(24'h000007, 24'h000005, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0));
        vecs.push_back(mk(24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1));
`endif
        for (int i = 0; i < 6; i++) begin
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom);
`ifdef ADDER_SEQ_SUB_EN
            v.sub = 1'($urandom);
`else
            v.sub = 1'b0;
`endif
            vecs.push_back(model(v));
        end

        // Table ops issue back-to-back, each accepted in the previous DONE cycle.
        foreach (vecs[i]) issue(vecs[i], $sformatf("vec%0d", i));

        // start_i held through BUSY with junk operands; second op taken in DONE.
        wait_ready(ok);
        if (ok) begin
            drive(mk(24'h00003F, 24'h000001, 1'b1, 1'b0, 24'h000041, 1'b0, 1'b0), "hold1");
            repeat (4) begin
                @(negedge clk);
                bus_if.data0_i = W'($urandom);
                bus_if.data1_i = W'($urandom);
                bus_if.carry_i = 1'($urandom);
            end
            @(negedge clk);
            check("hold_done_ready", W'(bus_if.ready_o), W'(1));
            drive(mk(24'h000100, 24'h0000FF, 1'b0, 1'b0, 24'h0001FF, 1'b0, 1'b0), "hold2");
            @(posedge clk);
            #1 bus_if.start_i = 1'b0;
            wait_ready(ok);
            @(negedge clk);
            check("hold_valid_spacing", W'(last_valid - prev_valid), W'(NSLICE + 1));
        end

        // Reset on the edge that would write slice 2: operation is dropped.
        wait_ready(ok);
        if (ok) begin
            bus_if.start_i = 1'b1;
            bus_if.data0_i = 24'h123456;
            bus_if.data1_i = 24'h111111;
            bus_if.carry_i = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
            bus_if.sub_i   = 1'b0;
`endif
            @(posedge clk);
            #1 bus_if.start_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("abort_partial_sum", W'(bus_if.sum_o[11:0]), W'(12'h567));
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("abort_ready", W'(bus_if.ready_o), W'(1));
            check("abort_valid", W'(bus_if.valid_o), W'(0));
            check("abort_sum", bus_if.sum_o, 24'h000000);
            check("abort_carry", W'(bus_if.carry_o), W'(0));
            check("abort_ovf", W'(bus_if.overflow_o), W'(0));
            repeat (6) @(negedge clk);
        end
        issue(mk(24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0), "after_abort");

        // Drain outstanding results.
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_seq24.md
# adder_seq24

Sequential multi-precision adder/subtractor that drives one `adder6` slice per clock to add two NSLICE×6-bit operands, least-significant slice first.
- Sits directly upstream of the `adder6` instance it owns:
  - selects the operand slices it adds each cycle;
  - registers the slice sum and carry-out between cycles.
- Gives the datapath wide additions without a long combinational ripple chain.
- Wide operands are accepted with a start/ready handshake; results are returned with a one-cycle valid pulse.

## Interface
- NSLICE, default 4: number of 6-bit slices; operand width W = 6*NSLICE (24 by default); legal range 2..8.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  request; accepted only on a rising edge where ready_o=1.
- data0_i  input  W  operand A, sampled on accept.
- data1_i  input  W  operand B, sampled on accept.
- carry_i  input  1  carry-in for addition, sampled on accept.
- sub_i  input  1  present only with ADDER_SEQ_SUB_EN; 1 = compute A−B; sampled on accept.
- ready_o  output  1  high in IDLE and DONE.
- valid_o  output  1  one-cycle pulse; result outputs are final.
- sum_o  output  W  result register.
- carry_o  output  1  carry out of the MSB slice.
- overflow_o  output  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start_i=1 → latch A, B', cin and mode; clear slice index to 0; go to BUSY.
  - BUSY: each edge, the `adder6` instance adds A[6i+5:6i], B'[6i+5:6i] and the carry register. The edge writes the slice sum into sum_o[6i+5:6i] and the slice carry-out into the carry register, then increments i.
  - BUSY, on the edge processing slice NSLICE−1: go to DONE.
  - DONE: valid_o=1. If start_i=1, accept the new operation exactly as in IDLE and go to BUSY. Otherwise go to IDLE.
- Addition: B' = B, initial carry = carry_i.
- carry_o = carry register after the last slice.
- overflow_o = (A[W−1] == B'[W−1]) && (sum_o[W−1] != A[W−1]), registered with the last slice.
- start_i in BUSY: ignored; no effect on the operation in flight.
- sum_o holds partial results during BUSY.
- sum_o, carry_o and overflow_o hold their values from DONE until the next accepted start. On the accept edge, carry_o and overflow_o clear to 0.
- Reset, at any time including mid-operation, forces:
  - state IDLE, slice index 0, carry register 0;
  - sum_o=0, carry_o=0, overflow_o=0, valid_o=0, ready_o=1.
  The in-flight operation is discarded with no valid_o pulse.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Start accepted on edge k.
- Slice i is written on edge k+1+i.
- DONE is entered on edge k+NSLICE; valid_o is high for the cycle after that edge.
- Latency from accept edge to valid_o: NSLICE cycles (4 by default).
- Back-to-back throughput: one operation per NSLICE+1 cycles (start asserted during DONE).
- ready_o and valid_o are decoded directly from state registers; no combinational path from start_i.

## Configuration
- ADDER_SEQ_SUB_EN defined:
  - sub_i port exists.
  - When sub_i=1 at accept: B' = ~B, initial carry = 1, and carry_i is ignored.
  - carry_o = 1 means no borrow.
  - overflow_o uses B' as above.
- ADDER_SEQ_SUB_EN undefined:
  - no sub_i port; the block only adds.
  - B' = B always.

## Test plan
- Reset: assert rst_i for 2 edges, including once mid-BUSY → next cycle ready_o=1, valid_o=0, sum_o=0x000000, carry_o=0, overflow_o=0.
- A=0xFFFFFF, B=0x000001, carry_i=0 → valid_o pulses in the cycle after the 4th edge following accept; sum_o=0x000000, carry_o=1, overflow_o=0.
- A=0x7FFFFF, B=0x000001, carry_i=0 → sum_o=0x800000, carry_o=0, overflow_o=1.
- With ADDER_SEQ_SUB_EN: A=0x000005, B=0x000007, sub_i=1, carry_i=1 → sum_o=0xFFFFFE, carry_o=0, overflow_o=0.
- Hold start_i=1 throughout BUSY:
  - first op A=0x00003F, B=0x000001, carry_i=1 → sum_o=0x000041, with no restart while BUSY;
  - second op accepted in the DONE cycle;
  - valid_o pulses 5 cycles apart.
- Assert rst_i on the edge that would write slice 2 → no valid_o pulse. A following op A=0x123456, B=0x111111 → sum_o=0x234567, carry_o=0.
